counter_run_arbiter: RTL and testbench

- Shares a single CNT_W-bit up-counter between NUM_REQ requesters.
- Each requester asks for a counting run of programmable length. The block grants the counter to one requester at a time in round-robin order, sequences the run and signals completion.
- Sits between client logic and the shared counter datapath. It owns the counter state internally and exposes it as cnt_value / cnt_enable.

---
 rtl/counter_run_arbiter.sv | 137 +++++++++++++
 tb/tb_counter_run_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_run_arbiter.sv
// counter_run_arbiter: round-robin owner of one shared CNT_W-bit up-counter.
// A granted requester gets a counting run 0..len (len latched at grant).
// The run ends with a one-cycle done pulse, or is aborted if its request drops.
// Every output comes straight from a flop.
module counter_run_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     cnt_enable,
    output logic [CNT_W-1:0]         cnt_value,
    output logic                     busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]   r_win, w_win_nxt;
    logic [IDX_W-1:0]   w_pick, w_win_inc;
    logic               w_pick_vld;
    logic [CNT_W-1:0]   r_len, w_len_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [NUM_REQ-1:0] r_done, w_done_nxt;
    logic               r_en, w_en_nxt;
    logic               r_busy;

    // Round-robin pick: first asserted request at or above the pointer, wrapping.
    // The scan runs from the farthest offset down so the nearest hit wins.
    always_comb begin
        int idx;
        w_pick     = '0;
        w_pick_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                w_pick     = IDX_W'(idx);
                w_pick_vld = 1'b1;
            end
        end
    end

    // Pointer value after a run finishes or aborts: one past the last owner.
    assign w_win_inc = (r_win == IDX_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;

    // Next-state and next-output logic for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_win_nxt   = r_win;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_en_nxt    = r_en;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = RUN;
                    w_win_nxt   = w_pick;
                    w_len_nxt   = req_len[w_pick*CNT_W +: CNT_W];
                    w_cnt_nxt   = '0;
                    w_en_nxt    = 1'b1;
                    w_gnt_nxt   = NUM_REQ'(1) << w_pick;
                end
            end
            RUN: begin
                if (!req[r_win]) begin
                    // Owner withdrew: drop everything silently, move priority on.
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_en_nxt    = 1'b0;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = w_win_inc;
                end else if (r_cnt == r_len) begin
                    w_state_nxt = DONE;
                    w_gnt_nxt   = '0;
                    w_en_nxt    = 1'b0;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = NUM_REQ'(1) << r_win;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DONE: begin
                // No arbitration here: guarantees an idle cycle between runs.
                w_state_nxt = IDLE;
                w_ptr_nxt   = w_win_inc;
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_en_nxt    = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_win   <= w_win_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_en    <= w_en_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    assign gnt        = r_gnt;
    assign done       = r_done;
    assign cnt_enable = r_en;
    assign cnt_value  = r_cnt;
    assign busy       = r_busy;

endmodule

// File: tb/tb_counter_run_arbiter.sv
// Bench for counter_run_arbiter: directed scenarios, an integer-level model
// checked on every cycle, plus hand-computed literal expectations.
module tb_counter_run_arbiter;
    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_len = '0;
    logic [N-1:0]   gnt, done;
    logic           cnt_enable, busy;
    logic [W-1:0]   cnt_value;

    int n_chk = 0;
    int n_fail = 0;

    counter_run_arbiter #(.NUM_REQ(N), .CNT_W(W)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_len(req_len),
        .gnt(gnt), .done(done), .cnt_enable(cnt_enable),
        .cnt_value(cnt_value), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: owner (-1 none), count, latched length, done owner (-1 none), pointer.
    int m_own = -1, m_cnt = 0, m_len = 0, m_done = -1, m_ptr = 0;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_own <= -1; m_cnt <= 0; m_len <= 0; m_done <= -1; m_ptr <= 0;
        end else if (m_done >= 0) begin
            m_done <= -1;
            m_ptr  <= (m_done + 1) % N;
        end else if (m_own >= 0) begin
            if (!req[m_own]) begin
                m_own <= -1; m_cnt <= 0; m_ptr <= (m_own + 1) % N;
            end else if (m_cnt == m_len) begin
                m_done <= m_own; m_own <= -1; m_cnt <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (req != '0) begin
            m_own <= pick(req, m_ptr);
            m_len <= int'((req_len >> (pick(req, m_ptr) * W)) & ((1 << W) - 1));
            m_cnt <= 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: let the edge happen, then compare every output with the model.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("gnt", 32'(gnt), (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
        chk("done", 32'(done), (m_done >= 0) ? (32'd1 << m_done) : 32'd0);
        chk("cnt_enable", 32'(cnt_enable), 32'(m_own >= 0));
        chk("cnt_value", 32'(cnt_value), 32'(m_cnt));
        chk("busy", 32'(busy), 32'(m_own >= 0 || m_done >= 0));
    endtask

    task automatic set_len(input int i, input int v);
        req_len[i*W +: W] = W'(v);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    // Run one requester alone to completion and report what was seen.
    task automatic run_one(input int idx, input int len, output int en, output int bz,
                           output int last, output int got);
        set_len(idx, len);
        req = N'(1) << idx;
        en = 0; bz = 0; last = 0; got = 0;
        for (int k = 0; k < 40 && got == 0; k++) begin
            tick();
            en += int'(cnt_enable);
            bz += int'(busy);
            if (cnt_enable) last = int'(cnt_value);
            if (done[idx]) got = 1;
        end
        req = '0;
        tick();
    endtask

    initial begin
        int en, bz, last, got, no, hit;
        int ord[4];

        #12;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(cnt_value), 32'd0);
        chk("rst_en", 32'(cnt_enable), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single request, length 3.
        run_one(0, 3, en, bz, last, got);
        chk("single_done", 32'(got), 32'd1);
        chk("single_en_cycles", 32'(en), 32'd4);
        chk("single_busy_cycles", 32'(bz), 32'd5);
        chk("single_last_cnt", 32'(last), 32'd3);

        // Round robin with all four requesting, zero lengths.
        do_reset();
        req_len = '0;
        req = 4'b1111;
        no = 0;
        for (int k = 0; k < 40 && (req != '0 || busy); k++) begin
            tick();
            if (gnt != '0 && no < 4) begin
                for (int i = 0; i < N; i++) if (gnt[i]) ord[no] = i;
                no++;
            end
            if (done != '0) req = req & ~done;
        end
        chk("rr_grants", 32'(no), 32'd4);
        for (int i = 0; i < 4; i++) chk("rr_order", 32'(ord[i]), 32'(i));

        // Zero and maximum length.
        run_one(2, 0, en, bz, last, got);
        chk("len0_done", 32'(got), 32'd1);
        chk("len0_en_cycles", 32'(en), 32'd1);
        chk("len0_last_cnt", 32'(last), 32'd0);
        run_one(1, 15, en, bz, last, got);
        chk("lenmax_done", 32'(got), 32'd1);
        chk("lenmax_en_cycles", 32'(en), 32'd16);
        chk("lenmax_last_cnt", 32'(last), 32'hF);

        // Abort with a pending requester.
        do_reset();
        set_len(0, 10);
        set_len(2, 2);
        req = 4'b0101;
        hit = 0;
        for (int k = 0; k < 30 && hit == 0; k++) begin
            tick();
            if (gnt[0] && cnt_value == 4'd4) hit = 1;
        end
        chk("abort_reach_cnt4", 32'(hit), 32'd1);
        req = 4'b0100;
        tick();
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_cnt", 32'(cnt_value), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        tick();
        chk("abort_next_gnt", 32'(gnt), 32'b0100);
        got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            tick();
            if (done[2]) got = 1;
        end
        chk("abort_req2_done", 32'(got), 32'd1);
        req = '0;
        tick();

        // Length latched at grant.
        set_len(0, 5);
        req = 4'b0001;
        tick();
        chk("latch_gnt", 32'(gnt), 32'b0001);
        set_len(0, 1);
        got = 0; last = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            tick();
            if (cnt_enable) last = int'(cnt_value);
            if (done[0]) got = 1;
        end
        chk("latch_done", 32'(got), 32'd1);
        chk("latch_last_cnt", 32'(last), 32'd5);
        req = '0;
        tick();

        // Asynchronous reset in the middle of a run.
        set_len(0, 5);
        req = 4'b0001;
        hit = 0;
        for (int k = 0; k < 20 && hit == 0; k++) begin
            tick();
            if (gnt[0] && cnt_value == 4'd2) hit = 1;
        end
        chk("arst_reach_cnt2", 32'(hit), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_en", 32'(cnt_enable), 32'd0);
        chk("arst_cnt", 32'(cnt_value), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        req = 4'b1010;
        #1 reset_n = 1'b1;
        tick();
        chk("arst_winner", 32'(gnt), 32'b0010);
        req = '0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard stop so the run can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
